rstmgr_crash_history: RTL and testbench
=======================================

// Module: rstmgr_crash_history
// PURPOSE
// - Multi-entry crash-dump store for rstmgr: keeps the last Depth dumps in a ring buffer.
// - Each dump is split into RdWidth-bit slots and read back through a registered request/valid port.
// - Sits beside the reset manager's CSR block: capture pulses come from alert/cpu crash sources.
// - CSR reads select an entry (0 = most recent) and a slot within it.
// PARAMETERS
// - CrashDumpWidth  32  bits per dump; may be any value >= 1.
// - RdWidth         32  readout word width.
// - Depth           4   dumps retained; power of two, 2..16.
// - IdxWidth        4   slot-select width; the total slot count must be < 2**IdxWidth.
// - TsWidth         16  timestamp width; used only when RSTMGR_CRASH_HISTORY_TS_EN is defined.
// - Derived: Slots = ceil(CrashDumpWidth/RdWidth), plus one more slot when the TS feature is on.
// - Derived: EntW = $clog2(Depth), CntW = $clog2(Depth+1).
// PORTS
// - clk_i           in   1               clock
// - rst_i           in   1               synchronous reset, active-high
// - dump_i          in   CrashDumpWidth  dump data, sampled on capture
// - dump_capture_i  in   1               single-cycle capture strobe
// - clear_i         in   1               empties the history
// - rd_req_i        in   1               read request, single-cycle
// - entry_sel_i     in   EntW            0 = newest, Depth-1 = oldest
// - slot_sel_i      in   IdxWidth        slot within the selected entry
// - rd_valid_o      out  1               read data valid (pulse)
// - rd_data_o       out  RdWidth         read data
// - rd_err_o        out  1               out-of-range read, qualified by rd_valid_o
// - slots_cnt_o     out  IdxWidth        constant Slots
// - entry_cnt_o     out  CntW            valid entries, saturates at Depth
// - overflow_o      out  1               sticky: a valid entry was overwritten
// BEHAVIOUR
// - Reset (rst_i=1 at posedge):
//   - wr_ptr=0, entry_cnt_o=0, overflow_o=0.
//   - rd_valid_o=0, rd_data_o=0, rd_err_o=0.
//   - Storage contents are also cleared to 0.
// - Capture:
//   - Writes dump_i, zero-padded to Slots*RdWidth, into mem[wr_ptr].
//   - wr_ptr increments modulo Depth.
//   - entry_cnt_o increments, saturating at Depth.
//   - Capture when entry_cnt_o==Depth: the oldest entry is overwritten and overflow_o is set.
// - Slot layout: slot k = padded dump bits [k*RdWidth +: RdWidth].
// - Entry mapping: entry e maps to mem[(wr_ptr-1-e) mod Depth]; this wraps around naturally.
// - clear_i:
//   - Next cycle: entry_cnt_o=0, wr_ptr=0, overflow_o=0.
//   - Storage data is not zeroed.
// - clear_i and dump_capture_i in the same cycle:
//   - Clear is applied first, then the capture.
//   - Result: mem[0]=dump_i, wr_ptr=1, entry_cnt_o=1, overflow_o=0.
// - Read:
//   - rd_req_i at cycle N gives rd_valid_o=1 at cycle N+1 for exactly one cycle.
//   - rd_data_o is held until the next request.
//   - Back-to-back requests are allowed, one per cycle, each with latency 1.
// - Read error: entry_sel_i >= entry_cnt_o, or slot_sel_i >= Slots.
//   - rd_err_o=1 and rd_data_o=0.
// - Read/write ordering: a read decodes against the pre-edge state.
//   - A capture or clear in the same cycle as rd_req_i is not visible to that read.
// - rd_req_i during reset is dropped; no rd_valid_o follows.
// - There is no FSM beyond the pointer/count registers and the one-stage read pipeline.
// CONFIGURATION
// - Macro: RSTMGR_CRASH_HISTORY_TS_EN.
// - Defined:
//   - A free-running TsWidth-bit cycle counter runs from 0 at reset and wraps at 2**TsWidth.
//   - The counter value is stored alongside each capture.
//   - It is readable at slot index Slots-1, zero-extended or truncated to RdWidth.
//   - clear_i does not reset the counter.
// - Undefined:
//   - No counter, no extra slot; Slots = ceil(CrashDumpWidth/RdWidth).
// TESTING
// - Reset, then rd_req_i with entry 0, slot 0
//   -> rd_valid_o=1 at the next cycle, rd_err_o=1, rd_data_o=0, entry_cnt_o=0.
// - CrashDumpWidth=40: capture 40'hAB_1234_5678, then read slots 0 and 1
//   -> 32'h12345678, then 32'h000000AB.
//   - Slot 2 read -> rd_err_o=1 (TS off).
// - Depth=4: capture 5 dumps with values 1..5 -> entry_cnt_o=4, overflow_o=1.
//   - Entries 0..3 read 5, 4, 3, 2.
// - clear_i together with a capture of 32'hDEAD -> entry_cnt_o=1, overflow_o=0.
//   - Entry 0 = 32'hDEAD; entry 1 read -> rd_err_o=1.
// - rd_req_i in the same cycle as a capture of 7 over an entry-0 value of 6
//   -> that read returns 6; the next read returns 7.
// - TS_EN: capture at counter value 100 -> the timestamp slot reads 100.
//   - Reset asserted mid-read drops rd_valid_o to 0.

Source files
------------

// File: rtl/rstmgr_crash_history.sv
// Ring buffer of the last Depth crash dumps, read back one RdWidth slot at a time.
// Optional per-capture timestamp slot enabled by defining RSTMGR_CRASH_HISTORY_TS_EN.
module rstmgr_crash_history #(
    parameter int CrashDumpWidth = 32,
    parameter int RdWidth        = 32,
    parameter int Depth          = 4,
    parameter int IdxWidth       = 4,
    parameter int TsWidth        = 16,
    localparam int EntW          = $clog2(Depth),
    localparam int CntW          = $clog2(Depth + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CrashDumpWidth-1:0] dump_i,
    input  logic                      dump_capture_i,
    input  logic                      clear_i,
    input  logic                      rd_req_i,
    input  logic [EntW-1:0]           entry_sel_i,
    input  logic [IdxWidth-1:0]       slot_sel_i,
    output logic                      rd_valid_o,
    output logic [RdWidth-1:0]        rd_data_o,
    output logic                      rd_err_o,
    output logic [IdxWidth-1:0]       slots_cnt_o,
    output logic [CntW-1:0]           entry_cnt_o,
    output logic                      overflow_o
);

    localparam int DataSlots = (CrashDumpWidth + RdWidth - 1) / RdWidth;
    localparam int PadW      = DataSlots * RdWidth;
`ifdef RSTMGR_CRASH_HISTORY_TS_EN
    localparam int Slots     = DataSlots + 1;
`else
    localparam int Slots     = DataSlots;
`endif

    if (Depth < 2 || Depth > 16 || (Depth & (Depth - 1)) != 0 || Slots >= 2 ** IdxWidth
        || TsWidth < 1 || CrashDumpWidth < 1) begin : g_param_check
        $error("rstmgr_crash_history: illegal parameter combination");
    end

    logic [PadW-1:0]    mem [Depth];
    logic [EntW-1:0]    wr_ptr;
    logic [EntW-1:0]    wr_base;
    logic [EntW-1:0]    wr_ptr_nxt;
    logic [CntW-1:0]    cnt_base;
    logic [CntW-1:0]    cnt_nxt;
    logic               ovf_nxt;
    logic [EntW-1:0]    rd_idx;
    logic               rd_err_nxt;
    logic [RdWidth-1:0] rd_word;
    logic [RdWidth-1:0] slot_words [Slots];
    logic [PadW-1:0]    dump_padded;

`ifdef RSTMGR_CRASH_HISTORY_TS_EN
    logic [TsWidth-1:0] ts_cnt;
    logic [TsWidth-1:0] ts_mem [Depth];
`endif

    assign dump_padded = PadW'(dump_i);
    assign slots_cnt_o = IdxWidth'(Slots);

    // A same-cycle clear is folded in before the capture so the capture lands in an empty history.
    always_comb begin
        wr_base    = clear_i ? '0 : wr_ptr;
        cnt_base   = clear_i ? '0 : entry_cnt_o;
        wr_ptr_nxt = wr_base;
        cnt_nxt    = cnt_base;
        ovf_nxt    = clear_i ? 1'b0 : overflow_o;
        if (dump_capture_i) begin
            wr_ptr_nxt = wr_base + EntW'(1);
            if (cnt_base == CntW'(Depth)) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_base + CntW'(1);
            end
        end
    end

    // Reads decode against the pre-edge pointer and count; entry 0 is the newest capture.
    always_comb begin
        rd_idx = wr_ptr - EntW'(1) - entry_sel_i;
        for (int k = 0; k < DataSlots; k++) begin
            slot_words[k] = mem[rd_idx][k*RdWidth +: RdWidth];
        end
`ifdef RSTMGR_CRASH_HISTORY_TS_EN
        slot_words[Slots-1] = RdWidth'(ts_mem[rd_idx]);
`endif
        rd_err_nxt = (CntW'(entry_sel_i) >= entry_cnt_o) || (slot_sel_i >= IdxWidth'(Slots));
        rd_word    = '0;
        for (int k = 0; k < Slots; k++) begin
            if (slot_sel_i == IdxWidth'(k)) begin
                rd_word = slot_words[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            entry_cnt_o <= '0;
            overflow_o  <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_err_o    <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
`ifdef RSTMGR_CRASH_HISTORY_TS_EN
            ts_cnt <= '0;
            for (int i = 0; i < Depth; i++) begin
                ts_mem[i] <= '0;
            end
`endif
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            entry_cnt_o <= cnt_nxt;
            overflow_o  <= ovf_nxt;
            if (dump_capture_i) begin
                mem[wr_base] <= dump_padded;
            end
`ifdef RSTMGR_CRASH_HISTORY_TS_EN
            ts_cnt <= ts_cnt + TsWidth'(1);
            if (dump_capture_i) begin
                ts_mem[wr_base] <= ts_cnt;
            end
`endif
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_err_o  <= rd_err_nxt;
                rd_data_o <= rd_err_nxt ? '0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_rstmgr_crash_history.sv
// Directed bench for rstmgr_crash_history with a 40-bit dump (two data slots, depth 4).
module tb_rstmgr_crash_history;

    localparam int DW = 40;
`ifdef RSTMGR_CRASH_HISTORY_TS_EN
    localparam int SLOTS = 3;
`else
    localparam int SLOTS = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [DW-1:0] dump = '0;
    logic        cap = 1'b0;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [1:0]  ent = '0;
    logic [3:0]  slot = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [3:0]  slots_cnt;
    logic [2:0]  entry_cnt;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ts_model = 0;

    rstmgr_crash_history #(
        .CrashDumpWidth(DW), .RdWidth(32), .Depth(4), .IdxWidth(4), .TsWidth(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .dump_i(dump), .dump_capture_i(cap), .clear_i(clr),
        .rd_req_i(rd_req), .entry_sel_i(ent), .slot_sel_i(slot),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
        .slots_cnt_o(slots_cnt), .entry_cnt_o(entry_cnt), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cap;
        logic        clr;
        logic [DW-1:0] dump;
        logic        rd;
        logic [1:0]  ent;
        logic [3:0]  slot;
        logic        ev;
        logic        ee;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        if (rst) ts_model = 0;
        else ts_model = ts_model + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic c, input logic cl, input logic [DW-1:0] d,
                                input logic r, input logic [1:0] e, input logic [3:0] s,
                                input logic ev, input logic ee, input logic [31:0] ed,
                                input logic [2:0] ec, input logic eo);
        vec_t v;
        v.cap = c; v.clr = cl; v.dump = d; v.rd = r; v.ent = e; v.slot = s;
        v.ev = ev; v.ee = ee; v.ed = ed; v.ec = ec; v.eo = eo;
        vecs.push_back(v);
    endfunction

    initial begin
        //  cap clr dump            rd ent slot  ev ee data          cnt ovf
        add(0, 0, '0,              1, 0, 0,     1, 1, 32'h0,        0, 0);
        add(0, 0, '0,              0, 0, 0,     0, 0, 32'h0,        0, 0);
        add(1, 0, 40'hAB12345678,  0, 0, 0,     0, 0, 32'h0,        1, 0);
        add(0, 0, '0,              1, 0, 0,     1, 0, 32'h12345678, 1, 0);
        add(0, 0, '0,              1, 0, 1,     1, 0, 32'h000000AB, 1, 0);
        add(0, 0, '0,              0, 0, 0,     0, 0, 32'h000000AB, 1, 0);
        add(0, 0, '0,              1, 0, 4'(SLOTS), 1, 1, 32'h0,    1, 0);
        add(0, 0, '0,              1, 1, 0,     1, 1, 32'h0,        1, 0);
        add(0, 1, '0,              0, 0, 0,     0, 0, 32'h0,        0, 0);
        add(1, 0, 40'd1,           0, 0, 0,     0, 0, 32'h0,        1, 0);
        add(1, 0, 40'd2,           0, 0, 0,     0, 0, 32'h0,        2, 0);
        add(1, 0, 40'd3,           0, 0, 0,     0, 0, 32'h0,        3, 0);
        add(1, 0, 40'd4,           0, 0, 0,     0, 0, 32'h0,        4, 0);
        add(1, 0, 40'd5,           0, 0, 0,     0, 0, 32'h0,        4, 1);
        add(0, 0, '0,              1, 0, 0,     1, 0, 32'd5,        4, 1);
        add(0, 0, '0,              1, 1, 0,     1, 0, 32'd4,        4, 1);
        add(0, 0, '0,              1, 2, 0,     1, 0, 32'd3,        4, 1);
        add(0, 0, '0,              1, 3, 0,     1, 0, 32'd2,        4, 1);
        add(0, 0, '0,              1, 3, 1,     1, 0, 32'd0,        4, 1);
        add(1, 1, 40'hDEAD,        0, 0, 0,     0, 0, 32'd0,        1, 0);
        add(0, 0, '0,              1, 0, 0,     1, 0, 32'hDEAD,     1, 0);
        add(0, 0, '0,              1, 1, 0,     1, 1, 32'h0,        1, 0);
        add(1, 0, 40'd6,           0, 0, 0,     0, 0, 32'h0,        2, 0);
        add(1, 0, 40'd7,           1, 0, 0,     1, 0, 32'd6,        3, 0);
        add(0, 0, '0,              1, 0, 0,     1, 0, 32'd7,        3, 0);
        add(0, 1, '0,              1, 0, 0,     1, 0, 32'd7,        0, 0);
        add(0, 0, '0,              1, 0, 0,     1, 1, 32'h0,        0, 0);

        rst = 1'b1;
        step();
        step();
        check("reset_valid", 64'(rd_valid), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        check("reset_err", 64'(rd_err), 64'd0);
        check("reset_cnt", 64'(entry_cnt), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("slots_cnt", 64'(slots_cnt), 64'(SLOTS));
        rst = 1'b0;

        foreach (vecs[i]) begin
            cap = vecs[i].cap; clr = vecs[i].clr; dump = vecs[i].dump;
            rd_req = vecs[i].rd; ent = vecs[i].ent; slot = vecs[i].slot;
            step();
            check($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("v%0d_err", i), 64'(rd_err), 64'(vecs[i].ee));
            check($sformatf("v%0d_data", i), 64'(rd_data), 64'(vecs[i].ed));
            check($sformatf("v%0d_cnt", i), 64'(entry_cnt), 64'(vecs[i].ec));
            check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].eo));
        end
        cap = 1'b0; clr = 1'b0; rd_req = 1'b0;

        // Refill, then reset while a read is in flight: no valid pulse may survive.
        cap = 1'b1; dump = 40'h55;
        step();
        cap = 1'b0;
        rd_req = 1'b1; ent = 0; slot = 0; rst = 1'b1;
        step();
        check("rst_mid_read_valid", 64'(rd_valid), 64'd0);
        check("rst_mid_read_data", 64'(rd_data), 64'd0);
        check("rst_mid_read_cnt", 64'(entry_cnt), 64'd0);
        step();
        check("rd_during_rst_valid", 64'(rd_valid), 64'd0);
        rst = 1'b0; rd_req = 1'b0;
        step();
        check("rd_dropped_after_rst", 64'(rd_valid), 64'd0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("post_rst_read_valid", 64'(rd_valid), 64'd1);
        check("post_rst_read_err", 64'(rd_err), 64'd1);

`ifdef RSTMGR_CRASH_HISTORY_TS_EN
        for (int n = 0; n < 200 && ts_model != 100; n++) step();
        check("ts_reached", 64'(ts_model), 64'd100);
        cap = 1'b1; dump = 40'h1;
        step();
        cap = 1'b0;
        rd_req = 1'b1; ent = 0; slot = 4'(SLOTS - 1);
        step();
        rd_req = 1'b0;
        check("ts_slot_valid", 64'(rd_valid), 64'd1);
        check("ts_slot_err", 64'(rd_err), 64'd0);
        check("ts_slot_data", 64'(rd_data), 64'd100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
